// File: rtl/dmem_lat.sv
// dmem_lat: byte-addressed, big-endian data memory with a valid/ready
// request/response handshake and a configurable access latency (1..8).
// Out-of-range accesses set rsp_error, suppress the store and return zero.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned halfword/word accesses are
// reported as errors. When it is undefined, the low address bits are forced
// to zero instead.
module dmem_lat #(
  parameter int SIZE    = 16384,
  parameter int LATENCY = 1,
  parameter int AW      = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [0:AW-1] req_addr,
  input  logic          req_write,
  input  logic          req_byte,
  input  logic          req_half_word,
  input  logic          req_sign_extend,
  input  logic [0:31]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [0:31]   rsp_rdata,
  output logic          rsp_error
);

  localparam int         IW       = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [2:0]    cnt, cnt_nxt;
  logic [7:0]    mem [0:SIZE-1];

  logic [AW-1:0] addr_p0;
  logic [31:0]   wdata_p0;
  logic [31:0]   rdata_p0;
  logic          is_byte, is_half, is_word;
  logic [AW:0]   last_byte;
  logic          out_of_range, misaligned, acc_err, accept;
  logic [IW-1:0] idx0, idx1, idx2, idx3;
  logic [31:0]   rdata_p1;
  logic          err_p1;

  // Assemble big-endian load data and apply zero or sign extension.
  function automatic logic [31:0] load_fmt(input logic [7:0] b0, b1, b2, b3,
                                           input logic byte_acc, half_acc, sx);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] r;
    sb = signed'(b0);
    sh = signed'({b0, b1});
    if (byte_acc)      r = sx ? 32'(sb) : signed'({24'd0, b0});
    else if (half_acc) r = sx ? 32'(sh) : signed'({16'd0, b0, b1});
    else               r = signed'({b0, b1, b2, b3});
    return unsigned'(r);
  endfunction

  // Request decode: access size, range/alignment check, byte indices, load data.
  always_comb begin
    addr_p0   = req_addr;
    wdata_p0  = req_wdata;
    is_byte   = req_byte;
    is_half   = !req_byte && req_half_word;
    is_word   = !req_byte && !req_half_word;
    // Range is judged on the address as presented, before any masking.
    last_byte = {1'b0, addr_p0} + (is_byte ? (AW+1)'(0) :
                                   is_half ? (AW+1)'(1) : (AW+1)'(3));
    out_of_range = (last_byte >= (AW+1)'(SIZE));
    idx0 = addr_p0[IW-1:0];
`ifdef DMEM_ALIGN_CHECK_EN
    misaligned = (is_half && addr_p0[0]) || (is_word && (addr_p0[1:0] != 2'b00));
`else
    misaligned = 1'b0;
    if (is_half) idx0[0]   = 1'b0;
    if (is_word) idx0[1:0] = 2'b00;
`endif
    acc_err  = out_of_range || misaligned;
    idx1     = idx0 + IW'(1);
    idx2     = idx0 + IW'(2);
    idx3     = idx0 + IW'(3);
    rdata_p0 = load_fmt(mem[idx0], mem[idx1], mem[idx2], mem[idx3],
                        is_byte, is_half, req_sign_extend);
    accept   = (state == IDLE) && req_valid && !reset;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 3'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 3'd1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Response register: captured at accept, held until the consumer takes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_p1 <= 32'd0;
      err_p1   <= 1'b0;
    end else if (accept) begin
      rdata_p1 <= (acc_err || req_write) ? 32'd0 : rdata_p0;
      err_p1   <= acc_err;
    end
  end

  // Store commit on the accept edge; storage is never cleared by reset.
  always_ff @(posedge clock) begin
    if (accept && req_write && !acc_err) begin
      if (is_byte) begin
        mem[idx0] <= wdata_p0[7:0];
      end else if (is_half) begin
        mem[idx0] <= wdata_p0[15:8];
        mem[idx1] <= wdata_p0[7:0];
      end else begin
        mem[idx0] <= wdata_p0[31:24];
        mem[idx1] <= wdata_p0[23:16];
        mem[idx2] <= wdata_p0[15:8];
        mem[idx3] <= wdata_p0[7:0];
      end
    end
  end

  assign rsp_rdata = rdata_p1;
  assign rsp_error = err_p1;

endmodule

// File: tb/tb_dmem_lat.sv
// Testbench for dmem_lat: three instances (LATENCY 1, 3, 4) driven by
// directed steps; expected responses go through a scoreboard queue.
module tb_dmem_lat;

  localparam int SIZE = 16384;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] req_addr;
  logic        req_write, req_byte, req_half_word, req_sign_extend;
  logic [31:0] req_wdata;
  logic        req_valid [3];
  logic        rsp_ready [3];
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic        rsp_error [3];
  logic [31:0] rsp_rdata [3];

  int lat_tab [3] = '{1, 3, 4};

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t sb_q [$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  dmem_lat #(.SIZE(SIZE), .LATENCY(1), .AW(32)) u1 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr),
    .req_write(req_write), .req_byte(req_byte), .req_half_word(req_half_word),
    .req_sign_extend(req_sign_extend), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0]));

  dmem_lat #(.SIZE(SIZE), .LATENCY(3), .AW(32)) u3 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr),
    .req_write(req_write), .req_byte(req_byte), .req_half_word(req_half_word),
    .req_sign_extend(req_sign_extend), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1]));

  dmem_lat #(.SIZE(SIZE), .LATENCY(4), .AW(32)) u4 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_addr(req_addr),
    .req_write(req_write), .req_byte(req_byte), .req_half_word(req_half_word),
    .req_sign_extend(req_sign_extend), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_error(rsp_error[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance k; hold = cycles of rsp_ready=0 after rsp_valid.
  task automatic access(input int k, input logic [31:0] addr, input logic wr,
                        input logic bt, input logic hw, input logic sx,
                        input logic [31:0] wd, input logic [31:0] exp_d,
                        input logic exp_e, input int hold);
    rsp_t        e;
    int          n;
    logic [31:0] d0;
    sb_q.push_back({exp_d, exp_e});
    @(negedge clock);
    chk("req_ready_idle", 32'(req_ready[k]), 32'd1);
    req_addr = addr; req_write = wr; req_byte = bt; req_half_word = hw;
    req_sign_extend = sx; req_wdata = wd; req_valid[k] = 1'b1;
    @(negedge clock);
    req_valid[k] = 1'b0;
    chk("req_ready_busy", 32'(req_ready[k]), 32'd0);
    n = 0;
    while (!rsp_valid[k] && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("latency", n + 1, lat_tab[k]);
    d0 = rsp_rdata[k];
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("hold_valid", 32'(rsp_valid[k]), 32'd1);
      chk("hold_data", rsp_rdata[k], d0);
      chk("hold_req_ready", 32'(req_ready[k]), 32'd0);
    end
    rsp_ready[k] = 1'b1;
    e = sb_q.pop_front();
    chk("rdata", rsp_rdata[k], e.data);
    chk("error", 32'(rsp_error[k]), 32'(e.err));
    @(negedge clock);
    rsp_ready[k] = 1'b0;
    chk("valid_drop", 32'(rsp_valid[k]), 32'd0);
    chk("req_ready_back", 32'(req_ready[k]), 32'd1);
  endtask

  // Directed sequence.
  initial begin
    reset = 1'b1;
    req_addr = '0; req_write = 1'b0; req_byte = 1'b0; req_half_word = 1'b0;
    req_sign_extend = 1'b0; req_wdata = '0;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0;
      rsp_ready[k] = 1'b0;
    end
    repeat (2) @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      chk("rst_req_ready", 32'(req_ready[k]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      chk("rst_rdata", rsp_rdata[k], 32'd0);
      chk("rst_error", 32'(rsp_error[k]), 32'd0);
    end
    reset = 1'b0;

    // LATENCY=1: word store/load and big-endian byte layout
    access(0, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    chk("mem_10", 32'(u1.mem[32'h10]), 32'hDE);
    chk("mem_13", 32'(u1.mem[32'h13]), 32'hEF);
    access(0, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    access(0, 32'h11, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'hFFFFFFAD, 1'b0, 0);
    access(0, 32'h12, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000BEEF, 1'b0, 0);
    access(0, 32'h10, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h000000DE, 1'b0, 0);
    // byte store only touches one byte; byte has priority over halfword
    access(0, 32'h11, 1'b1, 1'b1, 1'b1, 1'b0, 32'h12345677, 32'h0, 1'b0, 0);
    access(0, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hDE77BEEF, 1'b0, 0);

    // Range boundary at the top of memory
    access(0, SIZE - 4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h11223344, 32'h0, 1'b0, 0);
    access(0, SIZE - 2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 0);
    access(0, SIZE - 2, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
    chk("mem_top_m2", 32'(u1.mem[SIZE - 2]), 32'h33);
    chk("mem_top_m1", 32'(u1.mem[SIZE - 1]), 32'h44);
    access(0, SIZE - 1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h00000044, 1'b0, 0);
    access(0, SIZE - 1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 0);

    // Halfword store at an odd address
    access(0, 32'h20, 1'b1, 1'b0, 1'b0, 1'b0, 32'h01020304, 32'h0, 1'b0, 0);
`ifdef DMEM_ALIGN_CHECK_EN
    access(0, 32'h21, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000CAFE, 32'h0, 1'b1, 0);
    chk("mem_20", 32'(u1.mem[32'h20]), 32'h01);
    chk("mem_21", 32'(u1.mem[32'h21]), 32'h02);
`else
    access(0, 32'h21, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000CAFE, 32'h0, 1'b0, 0);
    chk("mem_20", 32'(u1.mem[32'h20]), 32'hCA);
    chk("mem_21", 32'(u1.mem[32'h21]), 32'hFE);
`endif
    chk("mem_22", 32'(u1.mem[32'h22]), 32'h03);

    // LATENCY=4 with response backpressure
    access(2, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0, 32'h89ABCDEF, 32'h0, 1'b0, 0);
    access(2, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h89ABCDEF, 1'b0, 3);
    access(2, 32'h80, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'hFFFF89AB, 1'b0, 0);

    // LATENCY=3: reset one cycle after a store accept
    @(negedge clock);
    req_addr = 32'h40; req_write = 1'b1; req_byte = 1'b0; req_half_word = 1'b0;
    req_sign_extend = 1'b0; req_wdata = 32'hCAFEF00D; req_valid[1] = 1'b1;
    @(negedge clock);
    req_valid[1] = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_mid_req_ready", 32'(req_ready[1]), 32'd1);
    chk("rst_mid_valid", 32'(rsp_valid[1]), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("rst_mid_no_valid", 32'(rsp_valid[1]), 32'd0);
    end
    chk("rst_mid_mem", 32'(u3.mem[32'h40]), 32'hCA);
    access(1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 0);

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
